bell_arbiter: RTL and testbench



---
 rtl/musicbox_pkg.sv | 20 ++
 rtl/bell_arbiter_if.sv | 29 ++
 rtl/bell_arbiter_chirp_gen.sv | 46 ++++
 rtl/bell_arbiter.sv | 178 +++++++++++++++++
 tb/tb_bell_arbiter.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/musicbox_pkg.sv
// Shared types for the musicbox buzzer path: arbiter states and owner codes.
package musicbox_pkg;

    typedef enum logic [1:0] {
        BASE,
        GAP,
        CLICK,
        CHIRP
    } arb_state_t;

    localparam logic [1:0] OWN_A     = 2'd0;
    localparam logic [1:0] OWN_B     = 2'd1;
    localparam logic [1:0] OWN_CLICK = 2'd2;
    localparam logic [1:0] OWN_CHIRP = 2'd3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bell_arbiter_if.sv
// Buzzer sources, requests and the shared bell/en pins of the arbiter.
interface bell_arbiter_if;

    logic       base_sel;
    logic       src_a_wave;
    logic       src_a_en;
    logic       src_b_wave;
    logic       src_b_en;
    logic       overlay_en;
    logic       click_req;
    logic       chirp_req;
    logic       bell;
    logic       en;
    logic [1:0] owner;
    logic       busy;

    modport master (
        output base_sel, src_a_wave, src_a_en, src_b_wave, src_b_en,
        output overlay_en, click_req, chirp_req,
        input  bell, en, owner, busy
    );

    modport slave (
        input  base_sel, src_a_wave, src_a_en, src_b_wave, src_b_en,
        input  overlay_en, click_req, chirp_req,
        output bell, en, owner, busy
    );

endinterface

// File: rtl/bell_arbiter_chirp_gen.sv
// Chirp square wave: half-period counter and toggle flop, low after restart.
module chirp_gen #(
    parameter int HALF = 25000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic en,
    output logic wave_next
);

    localparam int W = $clog2(HALF + 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         wave_q, wave_d;

    always_comb begin
        cnt_d  = cnt_q;
        wave_d = wave_q;
        if (restart) begin
            cnt_d  = '0;
            wave_d = 1'b0;
        end else if (en) begin
            if (cnt_q == W'(HALF - 1)) begin
                cnt_d  = '0;
                wave_d = ~wave_q;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            wave_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wave_q <= wave_d;
        end
    end

    // The arbiter registers this into bell, so it sees the value wave_q takes next.
    assign wave_next = wave_d;

endmodule

// File: rtl/bell_arbiter.sv
// Buzzer owner arbiter: chirp > click > base, with a silent gap on every handover.
module bell_arbiter
    import musicbox_pkg::*;
#(
    parameter int GAP_CYC    = 1000,
    parameter int CLICK_CYC  = 2000000,
    parameter int CHIRP_CYC  = 5000000,
    parameter int CHIRP_HALF = 25000
) (
    input logic          clk,
    input logic          rst_n,
    bell_arbiter_if.slave bus
);

    localparam int GW = $clog2(GAP_CYC + 1);
    localparam int LW = $clog2(max_int(CLICK_CYC, CHIRP_CYC) + 1);

    arb_state_t    state_q, state_d;
    arb_state_t    target_q, target_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [LW-1:0] len_q, len_d;
    logic          base_own_q, base_own_d;
    logic          bell_q, bell_d;
    logic          en_q, en_d;
    logic [1:0]    owner_q, owner_d;
    logic          busy_q, busy_d;
    logic          chirp_restart;
    logic          chirp_wave;
    logic          click_ok;

    // Click only matters when the metronome is not already the base tone.
    assign click_ok = bus.click_req & bus.overlay_en & ~bus.base_sel;

    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        gap_d         = gap_q;
        len_d         = len_q;
        base_own_d    = base_own_q;
        chirp_restart = 1'b0;
        unique case (state_q)
            BASE: begin
                if (bus.chirp_req) begin
                    state_d  = GAP;
                    target_d = CHIRP;
                    gap_d    = '0;
                end else if (click_ok) begin
                    state_d  = GAP;
                    target_d = CLICK;
                    gap_d    = '0;
                end else if (bus.base_sel != base_own_q) begin
                    state_d  = GAP;
                    target_d = BASE;
                    gap_d    = '0;
                end
            end
            GAP: begin
                if (bus.chirp_req) begin
                    target_d = CHIRP;
                end else if (click_ok && target_q == BASE) begin
                    target_d = CLICK;
                end
                if (gap_q == GW'(GAP_CYC - 1)) begin
                    state_d = target_d;
                    gap_d   = '0;
                    len_d   = '0;
                    if (target_d == BASE) begin
                        base_own_d = bus.base_sel;
                    end
                    if (target_d == CHIRP) begin
                        chirp_restart = 1'b1;
                    end
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            CLICK: begin
                if (bus.chirp_req) begin
                    state_d  = GAP;
                    target_d = CHIRP;
                    gap_d    = '0;
                end else if (click_ok) begin
                    len_d = '0;
                end else if (len_q == LW'(CLICK_CYC - 1)) begin
                    state_d  = GAP;
                    target_d = BASE;
                    gap_d    = '0;
                end else begin
                    len_d = len_q + LW'(1);
                end
            end
            CHIRP: begin
                if (bus.chirp_req) begin
                    len_d         = '0;
                    chirp_restart = 1'b1;
                end else if (len_q == LW'(CHIRP_CYC - 1)) begin
                    state_d  = GAP;
                    target_d = BASE;
                    gap_d    = '0;
                end else begin
                    len_d = len_q + LW'(1);
                end
            end
        endcase
    end

    chirp_gen #(
        .HALF(CHIRP_HALF)
    ) u_chirp (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (chirp_restart),
        .en       (state_q == CHIRP),
        .wave_next(chirp_wave)
    );

    // Pins follow the state being entered, so a gap is silent for exactly GAP_CYC cycles.
    always_comb begin
        bell_d  = 1'b0;
        en_d    = 1'b0;
        owner_d = OWN_A;
        busy_d  = (state_d != BASE);
        unique case (state_d)
            BASE: begin
                bell_d  = base_own_d ? bus.src_b_wave : bus.src_a_wave;
                en_d    = base_own_d ? bus.src_b_en : bus.src_a_en;
                owner_d = base_own_d ? OWN_B : OWN_A;
            end
            GAP: begin
                unique case (target_d)
                    CHIRP:   owner_d = OWN_CHIRP;
                    CLICK:   owner_d = OWN_CLICK;
                    default: owner_d = bus.base_sel ? OWN_B : OWN_A;
                endcase
            end
            CLICK: begin
                bell_d  = bus.src_b_wave;
                en_d    = 1'b1;
                owner_d = OWN_CLICK;
            end
            CHIRP: begin
                bell_d  = chirp_wave;
                en_d    = 1'b1;
                owner_d = OWN_CHIRP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= GAP;
            target_q   <= BASE;
            gap_q      <= '0;
            len_q      <= '0;
            base_own_q <= 1'b0;
            bell_q     <= 1'b0;
            en_q       <= 1'b0;
            owner_q    <= OWN_A;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            gap_q      <= gap_d;
            len_q      <= len_d;
            base_own_q <= base_own_d;
            bell_q     <= bell_d;
            en_q       <= en_d;
            owner_q    <= owner_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.bell  = bell_q;
    assign bus.en    = en_q;
    assign bus.owner = owner_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_bell_arbiter.sv
// Directed bench for bell_arbiter: segment table plus hand-written reset sequence.
module tb_bell_arbiter;

    typedef enum int {K_GAP, K_A, K_B, K_CLK, K_CHP} kind_e;

    typedef struct {
        string      name;
        logic       click;
        logic       chirp;
        logic       ovl;
        logic       bsel;
        kind_e      kind;
        logic [1:0] own;
        int         ph;
        int         n;
    } seg_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic pa_w, pa_e, pb_w, pb_e;
    seg_t tbl[$];

    bell_arbiter_if bus ();

    bell_arbiter #(
        .GAP_CYC   (4),
        .CLICK_CYC (20),
        .CHIRP_CYC (40),
        .CHIRP_HALF(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic seg_t mk(string nm, logic ck, logic cp, logic ov,
                                logic bs, kind_e k, logic [1:0] ow,
                                int ph, int n);
        seg_t s;
        s.name = nm; s.click = ck; s.chirp = cp; s.ovl = ov; s.bsel = bs;
        s.kind = k; s.own = ow; s.ph = ph; s.n = n;
        return s;
    endfunction

    task automatic chk(string nm, int idx, logic [4:0] exp);
        logic [4:0] act;
        act = {bus.bell, bus.en, bus.owner, bus.busy};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] bell/en/owner/busy got %b want %b",
                     nm, idx, act, exp);
        end
    endtask

    task automatic drive_src();
        bus.src_a_wave = cyc[0];
        bus.src_a_en   = 1'b1;
        bus.src_b_wave = cyc[1];
        bus.src_b_en   = cyc[2];
    endtask

    task automatic tick();
        pa_w = bus.src_a_wave; pa_e = bus.src_a_en;
        pb_w = bus.src_b_wave; pb_e = bus.src_b_en;
        @(posedge clk);
        #1;
        bus.click_req = 1'b0;
        bus.chirp_req = 1'b0;
        cyc++;
        drive_src();
    endtask

    task automatic run_seg(seg_t s);
        logic [4:0] exp;
        int         k;
        logic       cw;
        for (int i = 0; i < s.n; i++) begin
            bus.overlay_en = s.ovl;
            bus.base_sel   = s.bsel;
            if (i == 0) begin
                bus.click_req = s.click;
                bus.chirp_req = s.chirp;
            end
            tick();
            k  = s.ph + i;
            cw = ((k / 3) % 2) == 1;
            unique case (s.kind)
                K_GAP: exp = {1'b0, 1'b0, s.own, 1'b1};
                K_A:   exp = {pa_w, pa_e, 2'd0, 1'b0};
                K_B:   exp = {pb_w, pb_e, 2'd1, 1'b0};
                K_CLK: exp = {pb_w, 1'b1, 2'd2, 1'b1};
                K_CHP: exp = {cw, 1'b1, 2'd3, 1'b1};
            endcase
            chk(s.name, i, exp);
        end
    endtask

    initial begin
        bus.base_sel   = 1'b0;
        bus.overlay_en = 1'b0;
        bus.click_req  = 1'b0;
        bus.chirp_req  = 1'b0;
        drive_src();

        tbl.push_back(mk("rst_gap",      0, 0, 0, 0, K_GAP, 2'd0, 0, 3));
        tbl.push_back(mk("base_a",       0, 0, 0, 0, K_A,   2'd0, 0, 6));
        tbl.push_back(mk("click_gap",    1, 0, 1, 0, K_GAP, 2'd2, 0, 4));
        tbl.push_back(mk("click",        0, 0, 1, 0, K_CLK, 2'd0, 0, 20));
        tbl.push_back(mk("click_close",  0, 0, 1, 0, K_GAP, 2'd0, 0, 4));
        tbl.push_back(mk("a_again",      0, 0, 1, 0, K_A,   2'd0, 0, 4));
        tbl.push_back(mk("ovl_off",      1, 0, 0, 0, K_A,   2'd0, 0, 6));
        tbl.push_back(mk("click2_gap",   1, 0, 1, 0, K_GAP, 2'd2, 0, 4));
        tbl.push_back(mk("click2",       0, 0, 1, 0, K_CLK, 2'd0, 0, 20));
        tbl.push_back(mk("click_retrig", 1, 0, 1, 0, K_CLK, 2'd0, 0, 20));
        tbl.push_back(mk("click2_close", 0, 0, 1, 0, K_GAP, 2'd0, 0, 4));
        tbl.push_back(mk("a3",           0, 0, 1, 0, K_A,   2'd0, 0, 3));
        tbl.push_back(mk("click3_gap",   1, 0, 1, 0, K_GAP, 2'd2, 0, 4));
        tbl.push_back(mk("click3",       0, 0, 1, 0, K_CLK, 2'd0, 0, 10));
        tbl.push_back(mk("chirp_gap",    0, 1, 1, 0, K_GAP, 2'd3, 0, 4));
        tbl.push_back(mk("chirp",        0, 0, 1, 0, K_CHP, 2'd0, 0, 10));
        tbl.push_back(mk("chirp_click",  1, 0, 1, 0, K_CHP, 2'd0, 10, 20));
        tbl.push_back(mk("chirp_retrig", 0, 1, 1, 0, K_CHP, 2'd0, 0, 40));
        tbl.push_back(mk("chirp_close",  0, 0, 1, 0, K_GAP, 2'd0, 0, 4));
        tbl.push_back(mk("a4",           0, 0, 1, 0, K_A,   2'd0, 0, 3));
        tbl.push_back(mk("sel_b_gap",    0, 0, 1, 1, K_GAP, 2'd1, 0, 4));
        tbl.push_back(mk("base_b",       0, 0, 1, 1, K_B,   2'd0, 0, 6));
        tbl.push_back(mk("sel_a_gap",    0, 0, 1, 0, K_GAP, 2'd0, 0, 4));
        tbl.push_back(mk("a5",           0, 0, 1, 0, K_A,   2'd0, 0, 3));
        tbl.push_back(mk("chirp2_gap",   0, 1, 1, 0, K_GAP, 2'd3, 0, 4));
        tbl.push_back(mk("chirp2",       0, 0, 1, 0, K_CHP, 2'd0, 0, 15));
        tbl.push_back(mk("chirp2_sel",   0, 0, 1, 1, K_CHP, 2'd0, 15, 25));
        tbl.push_back(mk("chirp2_close", 0, 0, 1, 1, K_GAP, 2'd1, 0, 4));
        tbl.push_back(mk("base_b2",      0, 0, 1, 1, K_B,   2'd0, 0, 4));
        tbl.push_back(mk("sel_a2",       0, 0, 1, 0, K_GAP, 2'd0, 0, 4));
        tbl.push_back(mk("a6",           0, 0, 1, 0, K_A,   2'd0, 0, 3));
        tbl.push_back(mk("raise_gap",    1, 0, 1, 0, K_GAP, 2'd2, 0, 2));
        tbl.push_back(mk("raise_chirp",  0, 1, 1, 0, K_GAP, 2'd3, 0, 2));
        tbl.push_back(mk("raise_run",    0, 0, 1, 0, K_CHP, 2'd0, 0, 40));
        tbl.push_back(mk("raise_close",  0, 0, 1, 0, K_GAP, 2'd0, 0, 4));
        tbl.push_back(mk("a7",           0, 0, 1, 0, K_A,   2'd0, 0, 3));
        tbl.push_back(mk("both_gap",     1, 1, 1, 0, K_GAP, 2'd3, 0, 4));
        tbl.push_back(mk("both_chirp",   0, 0, 1, 0, K_CHP, 2'd0, 0, 10));

        repeat (2) tick();
        chk("reset", 0, 5'b00_00_1);
        rst_n = 1'b1;

        foreach (tbl[i]) run_seg(tbl[i]);

        rst_n = 1'b0;
        #1;
        chk("rst_async", 0, 5'b00_00_1);
        tick();
        tick();
        chk("rst_hold", 0, 5'b00_00_1);
        rst_n = 1'b1;
        run_seg(mk("post_rst_gap", 0, 0, 1, 0, K_GAP, 2'd0, 0, 3));
        run_seg(mk("post_rst_a",   0, 0, 1, 0, K_A,   2'd0, 0, 3));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
